// File: rtl/ibex_multdiv_iter.sv
// -----------------------------------------------------------------------------
// ibex_multdiv_iter
//
// Iterative RV32M multiply/divide unit. It performs one add/subtract per cycle
// on the shared ALU adder: shift-add for MULL/MULH and restoring division for
// DIV/REM. Signed operands are made positive first, and the sign is applied
// to the result at the end.
//
// Ports
//   clk_i             clock
//   rst_ni            asynchronous reset, active low
//   mult_en_i         multiply request, held until valid_o
//   div_en_i          divide request, held until valid_o
//   operator_i        00 MULL, 01 MULH, 10 DIV, 11 REM
//   signed_mode_i     [0] op_a signed, [1] op_b signed
//   op_a_i, op_b_i    operands, stable while a request is high
//   alu_adder_ext_i   ALU sum in bits [32:1], carry-out in bit 33
//   alu_multdiv_en_o  routes alu_operand_a_o/b_o into the ALU adder
//   alu_operand_a_o   ALU adder input A
//   alu_operand_b_o   ALU adder input B
//   multdiv_result_o  result, non-zero only while valid_o is high
//   valid_o           single-cycle completion strobe
//
// Configuration
//   IBEX_MD_EARLY_EXIT_EN : MULL leaves COMP as soon as the multiplier bits
//                           still to be consumed are all zero.
// -----------------------------------------------------------------------------
module ibex_multdiv_iter (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        mult_en_i,
   input  logic        div_en_i,
   input  logic [1:0]  operator_i,
   input  logic [1:0]  signed_mode_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   input  logic [33:0] alu_adder_ext_i,
   output logic        alu_multdiv_en_o,
   output logic [32:0] alu_operand_a_o,
   output logic [32:0] alu_operand_b_o,
   output logic [31:0] multdiv_result_o,
   output logic        valid_o
);

   typedef enum logic [2:0] {
      IDLE, ABS_A, ABS_B, COMP, CHANGE_SIGN, FINISH
   } md_state_e;

   localparam logic [1:0] OP_MULL = 2'b00;
   localparam logic [1:0] OP_MULH = 2'b01;
   localparam logic [1:0] OP_DIV  = 2'b10;

   md_state_e   state_q, state_d;
   logic [31:0] a_q, a_d;     // |op_a| (MULL: op_a shifted left each step)
   logic [31:0] b_q, b_d;     // |op_b|, the divisor
   logic [31:0] hi_q, hi_d;   // accumulator / product high word / remainder
   logic [31:0] lo_q, lo_d;   // multiplier / product low word / quotient
   logic [4:0]  cnt_q, cnt_d;
   logic        neg_q, neg_d;

   logic        en;
   logic        sign_a, sign_b;
   logic [31:0] sum;
   logic        carry;
   logic [31:0] shifted_rem;
   logic [31:0] abs_b;
   logic        unused_adder_lsb;

   assign en               = mult_en_i | div_en_i;
   assign sum              = alu_adder_ext_i[32:1];
   assign carry            = alu_adder_ext_i[33];
   assign unused_adder_lsb = alu_adder_ext_i[0];
   assign sign_a           = signed_mode_i[0] & op_a_i[31];
   assign sign_b           = signed_mode_i[1] & op_b_i[31];
   // Partial remainder shifted left with the next dividend bit brought in.
   assign shifted_rem      = {hi_q[30:0], lo_q[31]};
   assign abs_b            = sign_b ? sum : op_b_i;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
      end
   end

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d          = state_q;
      a_d              = a_q;
      b_d              = b_q;
      hi_d             = hi_q;
      lo_d             = lo_q;
      cnt_d            = cnt_q;
      neg_d            = neg_q;
      alu_multdiv_en_o = 1'b0;
      alu_operand_a_o  = '0;
      alu_operand_b_o  = '0;

      case (state_q)
         IDLE: begin
            if (en) begin
               if (operator_i == OP_MULL) begin
                  a_d     = op_a_i;
                  lo_d    = op_b_i;
                  hi_d    = '0;
                  cnt_d   = 5'd31;
                  state_d = COMP;
               end else if (operator_i[1] && (op_b_i == 32'd0)) begin
                  // Division by zero: quotient all ones, remainder = dividend.
                  lo_d    = '1;
                  hi_d    = op_a_i;
                  state_d = FINISH;
               end else begin
                  state_d = ABS_A;
               end
            end
         end

         ABS_A: begin
            // 0 - op_a through the adder's subtract encoding.
            alu_multdiv_en_o = 1'b1;
            alu_operand_a_o  = {32'd0, 1'b1};
            alu_operand_b_o  = {~op_a_i, 1'b1};
            a_d              = sign_a ? sum : op_a_i;
            // The remainder takes the sign of the dividend only.
            neg_d            = (operator_i == 2'b11) ? sign_a : (sign_a ^ sign_b);
            state_d          = ABS_B;
         end

         ABS_B: begin
            alu_multdiv_en_o = 1'b1;
            alu_operand_a_o  = {32'd0, 1'b1};
            alu_operand_b_o  = {~op_b_i, 1'b1};
            b_d              = abs_b;
            hi_d             = '0;
            lo_d             = (operator_i == OP_MULH) ? abs_b : a_q;
            cnt_d            = 5'd31;
            state_d          = COMP;
         end

         COMP: begin
            alu_multdiv_en_o = 1'b1;
            cnt_d            = cnt_q - 5'd1;
            case (operator_i)
               OP_MULL: begin
                  alu_operand_a_o = {hi_q, 1'b0};
                  alu_operand_b_o = {(lo_q[0] ? a_q : 32'd0), 1'b0};
                  hi_d            = sum;
                  a_d             = a_q << 1;
                  lo_d            = lo_q >> 1;
               end
               OP_MULH: begin
                  // Add, then shift the 65-bit {carry, hi, lo} right by one.
                  alu_operand_a_o = {hi_q, 1'b0};
                  alu_operand_b_o = {(lo_q[0] ? a_q : 32'd0), 1'b0};
                  hi_d            = {carry, sum[31:1]};
                  lo_d            = {sum[0], lo_q[31:1]};
               end
               default: begin
                  alu_operand_a_o = {shifted_rem, 1'b1};
                  alu_operand_b_o = {~b_q, 1'b1};
                  if (carry) begin
                     hi_d = sum;
                     lo_d = {lo_q[30:0], 1'b1};
                  end else begin
                     hi_d = shifted_rem;
                     lo_d = {lo_q[30:0], 1'b0};
                  end
               end
            endcase
            if (cnt_q == 5'd0) begin
               state_d = (operator_i == OP_MULL) ? FINISH : CHANGE_SIGN;
            end
`ifdef IBEX_MD_EARLY_EXIT_EN
            // lo_q[31:1] are the multiplier bits left after this step.
            if ((operator_i == OP_MULL) && (lo_q[31:1] == 31'd0)) begin
               state_d = FINISH;
            end
`endif
         end

         CHANGE_SIGN: begin
            alu_multdiv_en_o = 1'b1;
            case (operator_i)
               OP_MULH: begin
                  // Negating {hi,lo}: the +1 carries into hi only if lo is 0.
                  alu_operand_a_o = {~hi_q, 1'b0};
                  alu_operand_b_o = {31'd0, (lo_q == 32'd0), 1'b0};
                  if (neg_q) hi_d = sum;
               end
               OP_DIV: begin
                  alu_operand_a_o = {32'd0, 1'b1};
                  alu_operand_b_o = {~lo_q, 1'b1};
                  if (neg_q) lo_d = sum;
               end
               default: begin
                  alu_operand_a_o = {32'd0, 1'b1};
                  alu_operand_b_o = {~hi_q, 1'b1};
                  if (neg_q) hi_d = sum;
               end
            endcase
            state_d = FINISH;
         end

         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A dropped request abandons the operation at the next edge.
      if ((state_q != IDLE) && !en) begin
         state_d = IDLE;
      end
   end

   assign valid_o          = (state_q == FINISH) && en;
   assign multdiv_result_o = !valid_o              ? 32'd0 :
                             (operator_i == OP_DIV) ? lo_q  : hi_q;

   // Both request lines high at once is an illegal use of the unit.
   assert property (@(posedge clk_i) disable iff (!rst_ni) !(mult_en_i && div_en_i))
      else $error("mult_en_i and div_en_i both high");

endmodule
